parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
Sequences a single shared barrier gate between the entry lane and the exit lane of a single-lane car park. Arbitrates simultaneous entry/exit requests round-robin and runs the password handshake for entries. Owns the authoritative occupancy counter and enforces capacity. Sits between the lane sensors/keypad and the gate actuator, LEDs and display logic.

Parameters:
MAX_CAPACITY, 100, occupancy limit; full when count == MAX_CAPACITY (must be ≤ 255)
OPEN_CYCLES, 4, cycles gate_open is held per granted passage (≥ 1)
PW_TIMEOUT, 8, cycles allowed in WAIT_PW for pw_valid before error (≥ 1)
ERR_HOLD, 3, cycles spent in ERROR with err asserted (≥ 1)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  synchronous reset, ACTIVE-HIGH despite name (1 = reset)
entry_req  in  1  vehicle present at entry, level
exit_req  in  1  vehicle present at exit, level
pw_valid  in  1  keypad result strobe, 1 cycle
pw_ok  in  1  password correct; qualified by pw_valid
gate_open  out  1  barrier raise command
dir_in  out  1  1 = gate serving entry, 0 = exit; valid while gate_open
grant_entry  out  1  1-cycle pulse, entry accepted for password check
grant_exit  out  1  1-cycle pulse, exit accepted
count  out  8  current occupancy
full  out  1  count == MAX_CAPACITY (combinational from count)
err  out  1  high while in ERROR
state  out  3  IDLE=000, WAIT_PW=001, OPEN_IN=010, OPEN_OUT=011, ERROR=100

Behaviour:
- All outputs registered except full. Reset (rstn=1 at clk edge): state=IDLE, count=0, gate_open=0, dir_in=0, grants=0, err=0, timer=0, last_served=EXIT. Reset wins over all inputs and aborts any state, including mid-passage.
- IDLE: eligible_in = entry_req && !full; eligible_out = exit_req && count != 0.
  - Only eligible_in -> WAIT_PW, grant_entry=1 for the next cycle.
  - Only eligible_out -> OPEN_OUT, grant_exit=1, count-1 on the same edge.
  - Both eligible -> serve the side opposite last_served. After reset the first tie goes to entry.
  - Neither eligible -> stay in IDLE. Entry while full and exit while empty are ignored silently (no err).
- last_served updates on every grant.
- WAIT_PW: timer counts cycles spent in the state.
  - pw_valid && pw_ok -> OPEN_IN, count+1 on the same edge.
  - pw_valid && !pw_ok -> ERROR.
  - No pw_valid after PW_TIMEOUT cycles -> ERROR.
  - entry_req dropping does not abort; only timeout or pw_valid ends the state.
- OPEN_IN / OPEN_OUT: gate_open=1 and dir_in=1/0 for exactly OPEN_CYCLES cycles, then IDLE. Requests arriving meanwhile are held off and re-evaluated in IDLE.
- ERROR: err=1 for ERR_HOLD cycles, gate stays closed, then IDLE. count unchanged.
- Every return to IDLE spends at least 1 cycle there before the next grant.
- Latency: request sampled at edge k -> grant/state change visible after edge k. For exits, gate_open is high from edge k for OPEN_CYCLES cycles.
- Arithmetic: count never exceeds MAX_CAPACITY and never goes below 0. The guards are structural (eligibility), with no wrap-around.
- Simultaneous pw_valid and timeout expiry: pw_valid takes priority.

Test Plan:
1. Reset, then entry_req=1; 2 cycles later pw_valid=1, pw_ok=1 -> grant_entry pulse, state 001 then 010, gate_open=1 with dir_in=1 for 4 cycles, count=1, back to 000.
2. count=1, exit_req=1 -> grant_exit, count=0 on grant edge, gate_open=1 with dir_in=0 for 4 cycles. Then exit_req=1 at count=0 -> stays IDLE, no grant.
3. entry_req=1, pw_valid=1, pw_ok=0 -> ERROR, err=1 for 3 cycles, count unchanged. Repeat with no pw_valid -> ERROR after 8 cycles in WAIT_PW.
4. Drive count to 100 via entries: full=1, entry_req=1 ignored. exit_req=1 -> served, count=99, full=0. Next entry accepted, count=100.
5. entry_req=exit_req=1 held with count=5, pw_ok always correct -> grants alternate entry, exit, entry, …; count oscillates 6,5,6,5.
6. rstn=1 asserted mid-OPEN_IN (count=3) -> next cycle state=000, gate_open=0, count=0, last_served=EXIT.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
// Controls one barrier gate shared by the entry lane and the exit lane of a
// single-lane car park. Simultaneous requests are arbitrated round-robin, and
// entries run a password handshake. The block also holds the occupancy count
// and enforces capacity.
//
// Handshake semantics:
//   entry_req and exit_req are levels. They are sampled only in IDLE.
//   A grant is a 1-cycle pulse that is visible after the sampling edge.
//   pw_valid is a 1-cycle strobe. It qualifies pw_ok and is only consumed
//   in WAIT_PW. A strobe seen in any other state is ignored.
//
// All outputs come from registers except full, which is decoded from count.
// rstn is a synchronous ACTIVE-HIGH reset (1 = reset), despite its name.
module parking_gate_arbiter #(
  parameter int MAX_CAPACITY = 100,
  parameter int OPEN_CYCLES  = 4,
  parameter int PW_TIMEOUT   = 8,
  parameter int ERR_HOLD     = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       pw_valid,
  input  logic       pw_ok,
  output logic       gate_open,
  output logic       dir_in,
  output logic       grant_entry,
  output logic       grant_exit,
  output logic [7:0] count,
  output logic       full,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_WAIT_PW  = 3'b001,
    ST_OPEN_IN  = 3'b010,
    ST_OPEN_OUT = 3'b011,
    ST_ERROR    = 3'b100
  } state_t;

  typedef enum logic {
    SRV_EXIT  = 1'b0,
    SRV_ENTRY = 1'b1
  } side_t;

  // One timer is shared by every timed state, so it is sized for the
  // longest of the three intervals.
  localparam int T_MAX_A = (OPEN_CYCLES > PW_TIMEOUT) ? OPEN_CYCLES : PW_TIMEOUT;
  localparam int T_MAX   = (T_MAX_A > ERR_HOLD) ? T_MAX_A : ERR_HOLD;
  localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] PW_LAST   = TW'(PW_TIMEOUT - 1);
  localparam logic [TW-1:0] ERR_LAST  = TW'(ERR_HOLD - 1);
  localparam logic [7:0]    CAP       = 8'(MAX_CAPACITY);

  state_t        state_q, state_n;
  side_t         last_q, last_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [7:0]    count_q, count_n;
  logic          gate_q, gate_n;
  logic          dir_q, dir_n;
  logic          gnt_en_q, gnt_en_n;
  logic          gnt_ex_q, gnt_ex_n;
  logic          err_q, err_n;

  logic          elig_in, elig_out;
  logic          take_entry, take_exit;

  // Eligibility guards keep count between 0 and CAP without any wrap check.
  // On a tie, the side that was not served last gets the gate.
  always_comb begin
    elig_in    = entry_req && (count_q != CAP);
    elig_out   = exit_req && (count_q != 8'd0);
    take_entry = elig_in && (!elig_out || (last_q == SRV_EXIT));
    take_exit  = elig_out && !take_entry;
  end

  // Next-state and next-output logic. The defaults describe "hold".
  always_comb begin
    state_n  = state_q;
    last_n   = last_q;
    timer_n  = timer_q;
    count_n  = count_q;
    gate_n   = 1'b0;
    dir_n    = dir_q;
    gnt_en_n = 1'b0;
    gnt_ex_n = 1'b0;
    err_n    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_n = '0;
        if (take_entry) begin
          state_n  = ST_WAIT_PW;
          gnt_en_n = 1'b1;
          last_n   = SRV_ENTRY;
        end else if (take_exit) begin
          state_n  = ST_OPEN_OUT;
          gnt_ex_n = 1'b1;
          last_n   = SRV_EXIT;
          count_n  = count_q - 8'd1;
          gate_n   = 1'b1;
          dir_n    = 1'b0;
        end
      end

      ST_WAIT_PW: begin
        // A keypad strobe wins over timeout expiry on the same edge.
        if (pw_valid) begin
          timer_n = '0;
          if (pw_ok) begin
            state_n = ST_OPEN_IN;
            count_n = count_q + 8'd1;
            gate_n  = 1'b1;
            dir_n   = 1'b1;
          end else begin
            state_n = ST_ERROR;
            err_n   = 1'b1;
          end
        end else if (timer_q == PW_LAST) begin
          timer_n = '0;
          state_n = ST_ERROR;
          err_n   = 1'b1;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      ST_OPEN_IN, ST_OPEN_OUT: begin
        if (timer_q == OPEN_LAST) begin
          timer_n = '0;
          state_n = ST_IDLE;
        end else begin
          timer_n = timer_q + 1'b1;
          gate_n  = 1'b1;
        end
      end

      ST_ERROR: begin
        if (timer_q == ERR_LAST) begin
          timer_n = '0;
          state_n = ST_IDLE;
        end else begin
          timer_n = timer_q + 1'b1;
          err_n   = 1'b1;
        end
      end

      default: begin
        timer_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any passage in progress.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= ST_IDLE;
      last_q   <= SRV_EXIT;
      timer_q  <= '0;
      count_q  <= 8'd0;
      gate_q   <= 1'b0;
      dir_q    <= 1'b0;
      gnt_en_q <= 1'b0;
      gnt_ex_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      last_q   <= last_n;
      timer_q  <= timer_n;
      count_q  <= count_n;
      gate_q   <= gate_n;
      dir_q    <= dir_n;
      gnt_en_q <= gnt_en_n;
      gnt_ex_q <= gnt_ex_n;
      err_q    <= err_n;
    end
  end

  assign gate_open   = gate_q;
  assign dir_in      = dir_q;
  assign grant_entry = gnt_en_q;
  assign grant_exit  = gnt_ex_q;
  assign count       = count_q;
  assign err         = err_q;
  assign state       = state_q;
  assign full        = (count_q == CAP);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Testbench for parking_gate_arbiter.
// Stimulus tasks push the expected output events into exp_q. A monitor
// samples the outputs on every falling edge, turns what it sees into events,
// and pops exp_q to compare them.
module tb_parking_gate_arbiter;

  localparam int W = 15;

  localparam logic [2:0] EV_GEN   = 3'd1;
  localparam logic [2:0] EV_GEX   = 3'd2;
  localparam logic [2:0] EV_GRISE = 3'd3;
  localparam logic [2:0] EV_GFALL = 3'd4;
  localparam logic [2:0] EV_ERISE = 3'd5;
  localparam logic [2:0] EV_EFALL = 3'd6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       entry_req, exit_req, pw_valid, pw_ok;
  logic       gate_open, dir_in, grant_entry, grant_exit, full, err;
  logic [7:0] count;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .MAX_CAPACITY(100), .OPEN_CYCLES(4), .PW_TIMEOUT(8), .ERR_HOLD(3)
  ) dut (
    .clk(clk), .rstn(rstn), .entry_req(entry_req), .exit_req(exit_req),
    .pw_valid(pw_valid), .pw_ok(pw_ok), .gate_open(gate_open), .dir_in(dir_in),
    .grant_entry(grant_entry), .grant_exit(grant_exit), .count(count),
    .full(full), .err(err), .state(state)
  );

  // Event word layout: {kind[2:0], data[7:0], dir[0], state[2:0]}.
  function automatic logic [W-1:0] ev(input logic [2:0] k, input int d,
                                      input logic dr, input logic [2:0] s);
    return {k, 8'(d), dr, s};
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic prev_gate = 1'b0;
  logic prev_err  = 1'b0;
  int   gate_len  = 0;
  int   err_len   = 0;

  task automatic observe(input string name, input logic [W-1:0] got);
    logic [W-1:0] want;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event got %h expected none", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    logic dr;
    dr = gate_open ? dir_in : 1'b0;
    if (grant_entry === 1'b1) observe("grant_entry", ev(EV_GEN, int'(count), dr, state));
    if (grant_exit === 1'b1)  observe("grant_exit", ev(EV_GEX, int'(count), dr, state));
    if (gate_open === 1'b1 && !prev_gate) begin
      observe("gate_rise", ev(EV_GRISE, int'(count), dr, state));
      gate_len = 1;
    end else if (gate_open === 1'b1) begin
      gate_len++;
    end else if (prev_gate) begin
      observe("gate_len", ev(EV_GFALL, gate_len, dr, state));
      gate_len = 0;
    end
    if (err === 1'b1 && !prev_err) begin
      observe("err_rise", ev(EV_ERISE, int'(count), dr, state));
      err_len = 1;
    end else if (err === 1'b1) begin
      err_len++;
    end else if (prev_err) begin
      observe("err_len", ev(EV_EFALL, err_len, dr, state));
      err_len = 0;
    end
    prev_gate = (gate_open === 1'b1);
    prev_err  = (err === 1'b1);
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick(1);
    rstn = 1'b0;
    model_cnt = 0;
  endtask

  // Entry passage. pw_valid arrives wait_cyc cycles after the grant, or
  // never when send_pw is 0. keep sets the entry_req level after the grant.
  task automatic do_entry(input bit send_pw, input bit ok, input int wait_cyc,
                          input bit keep);
    entry_req = 1'b1;
    exp_q.push_back(ev(EV_GEN, model_cnt, 1'b0, 3'b001));
    tick(1);
    entry_req = keep;
    if (send_pw) begin
      tick(wait_cyc);
      pw_valid = 1'b1;
      pw_ok    = ok;
      if (ok) begin
        model_cnt++;
        exp_q.push_back(ev(EV_GRISE, model_cnt, 1'b1, 3'b010));
        exp_q.push_back(ev(EV_GFALL, 4, 1'b0, 3'b000));
      end else begin
        exp_q.push_back(ev(EV_ERISE, model_cnt, 1'b0, 3'b100));
        exp_q.push_back(ev(EV_EFALL, 3, 1'b0, 3'b000));
      end
      tick(1);
      pw_valid = 1'b0;
      pw_ok    = 1'b0;
      tick(ok ? 4 : 3);
    end else begin
      exp_q.push_back(ev(EV_ERISE, model_cnt, 1'b0, 3'b100));
      exp_q.push_back(ev(EV_EFALL, 3, 1'b0, 3'b000));
      tick(8);
      tick(3);
    end
  endtask

  task automatic do_exit(input bit keep);
    exit_req = 1'b1;
    model_cnt--;
    exp_q.push_back(ev(EV_GEX, model_cnt, 1'b0, 3'b011));
    exp_q.push_back(ev(EV_GRISE, model_cnt, 1'b0, 3'b011));
    exp_q.push_back(ev(EV_GFALL, 4, 1'b0, 3'b000));
    tick(1);
    exit_req = keep;
    tick(4);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rstn = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pw_valid = 1'b0; pw_ok = 1'b0;
    tick(2);
    rstn = 1'b0;
    check("rst_state", int'(state), 0);
    check("rst_count", int'(count), 0);
    check("rst_gate", int'(gate_open), 0);
    check("rst_err", int'(err), 0);
    check("rst_grants", int'({grant_entry, grant_exit}), 0);
    check("rst_full", int'(full), 0);

    // Test 1: entry with a correct password two cycles after the grant.
    do_entry(1'b1, 1'b1, 2, 1'b0);
    check("t1_count", int'(count), 1);
    check("t1_state", int'(state), 0);

    // Test 2: exit to empty, then an exit request while empty is ignored.
    do_exit(1'b0);
    check("t2_count", int'(count), 0);
    exit_req = 1'b1;
    tick(6);
    exit_req = 1'b0;
    check("t2_idle", int'(state), 0);

    // Test 3: wrong password, timeout, and a password on the last timeout cycle.
    do_entry(1'b1, 1'b0, 1, 1'b0);
    check("t3_count_bad_pw", int'(count), 0);
    do_entry(1'b0, 1'b0, 0, 1'b0);
    check("t3_count_timeout", int'(count), 0);
    do_entry(1'b1, 1'b1, 7, 1'b0);
    check("t3_count_late_pw", int'(count), 1);

    // Test 4: fill to capacity, ignore entry while full, exit, refill.
    for (int i = 0; i < 99; i++) do_entry(1'b1, 1'b1, 0, 1'b0);
    check("t4_count_full", int'(count), 100);
    check("t4_full", int'(full), 1);
    entry_req = 1'b1;
    tick(5);
    entry_req = 1'b0;
    check("t4_idle_when_full", int'(state), 0);
    do_exit(1'b0);
    check("t4_count_99", int'(count), 99);
    check("t4_not_full", int'(full), 0);
    do_entry(1'b1, 1'b1, 0, 1'b0);
    check("t4_count_refill", int'(count), 100);
    check("t4_full_again", int'(full), 1);

    // Test 5: both requests held at count 5 (exit served last) alternate.
    do_reset();
    for (int i = 0; i < 6; i++) do_entry(1'b1, 1'b1, 0, 1'b0);
    do_exit(1'b0);
    check("t5_start_count", int'(count), 5);
    entry_req = 1'b1;
    exit_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_entry(1'b1, 1'b1, 0, 1'b1);
      check("t5_count_after_entry", int'(count), 6);
      do_exit(1'b1);
      check("t5_count_after_exit", int'(count), 5);
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    tick(2);

    // Test 6: reset while the gate is open for an entry.
    do_reset();
    for (int i = 0; i < 3; i++) do_entry(1'b1, 1'b1, 0, 1'b0);
    check("t6_pre_count", int'(count), 3);
    entry_req = 1'b1;
    exp_q.push_back(ev(EV_GEN, 3, 1'b0, 3'b001));
    tick(1);
    entry_req = 1'b0;
    pw_valid = 1'b1;
    pw_ok    = 1'b1;
    exp_q.push_back(ev(EV_GRISE, 4, 1'b1, 3'b010));
    tick(1);
    pw_valid = 1'b0;
    pw_ok    = 1'b0;
    tick(1);
    exp_q.push_back(ev(EV_GFALL, 2, 1'b0, 3'b000));
    do_reset();
    check("t6_state", int'(state), 0);
    check("t6_gate", int'(gate_open), 0);
    check("t6_count", int'(count), 0);
    do_entry(1'b1, 1'b1, 0, 1'b0);
    check("t6_after_count", int'(count), 1);

    tick(3);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
